// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the IFU/LSU memory-port arbiter.
// Pure declarations; no logic, no latency, no backpressure.
package mem_arb_pkg;

  localparam int AW_DEF = 64;
  localparam int DW_DEF = 64;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  localparam logic GNT_IFU = 1'b0;
  localparam logic GNT_LSU = 1'b1;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of IFU, LSU and memory-port signals around the arbiter.
// Slave is the arbiter's view; master is the requesters-plus-memory view.
interface mem_arbiter_if #(
  parameter int AW = 64,
  parameter int DW = 64
);

  logic          ifu_valid;
  logic [AW-1:0] ifu_addr;
  logic          ifu_ready;
  logic          ifu_resp_valid;
  logic [DW-1:0] ifu_rdata;

  logic          lsu_valid;
  logic          lsu_wen;
  logic [AW-1:0] lsu_addr;
  logic [DW-1:0] lsu_wdata;
  logic [7:0]    lsu_mask;
  logic          lsu_ready;
  logic          lsu_resp_valid;
  logic [DW-1:0] lsu_rdata;

  logic          mem_ren;
  logic [AW-1:0] mem_raddr;
  logic [DW-1:0] mem_rdata;
  logic          mem_wen;
  logic [AW-1:0] mem_waddr;
  logic [DW-1:0] mem_wdata;
  logic [7:0]    mem_mask;

  modport slave (
    input  ifu_valid, ifu_addr,
    output ifu_ready, ifu_resp_valid, ifu_rdata,
    input  lsu_valid, lsu_wen, lsu_addr, lsu_wdata, lsu_mask,
    output lsu_ready, lsu_resp_valid, lsu_rdata,
    output mem_ren, mem_raddr, mem_wen, mem_waddr, mem_wdata, mem_mask,
    input  mem_rdata
  );

  modport master (
    output ifu_valid, ifu_addr,
    input  ifu_ready, ifu_resp_valid, ifu_rdata,
    output lsu_valid, lsu_wen, lsu_addr, lsu_wdata, lsu_mask,
    input  lsu_ready, lsu_resp_valid, lsu_rdata,
    input  mem_ren, mem_raddr, mem_wen, mem_waddr, mem_wdata, mem_mask,
    output mem_rdata
  );

endinterface

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way round-robin grant (bit 0 = IFU, bit 1 = LSU); purely combinational.
// On a tie the requester that did not win last time is granted.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] gnt,
  output logic       gnt_id
);

  always_comb begin
    gnt    = 2'b00;
    gnt_id = last_grant;
    case (req)
      2'b01: begin
        gnt    = 2'b01;
        gnt_id = GNT_IFU;
      end
      2'b10: begin
        gnt    = 2'b10;
        gnt_id = GNT_LSU;
      end
      2'b11: begin
        if (last_grant == GNT_LSU) begin
          gnt    = 2'b01;
          gnt_id = GNT_IFU;
        end else begin
          gnt    = 2'b10;
          gnt_id = GNT_LSU;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between IFU and LSU, one transaction at a time.
// Accept N, strobes N+1..N+LATENCY, response N+LATENCY+1; no response backpressure.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int LATENCY = 1,
  parameter int AW      = AW_DEF,
  parameter int DW      = DW_DEF
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_t        state, state_nxt;
  logic          last_grant;
  logic          gnt_id;
  logic [1:0]    gnt;
  logic          accept;
  logic [3:0]    cnt;
  logic          req_id;
  logic          req_wen;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [7:0]    req_mask;
  logic [DW-1:0] ifu_rdata_q;
  logic [DW-1:0] lsu_rdata_q;

  rr_arb2 u_rr (
    .req        ({bus.lsu_valid, bus.ifu_valid}),
    .last_grant (last_grant),
    .gnt        (gnt),
    .gnt_id     (gnt_id)
  );

  always_comb begin
    state_nxt          = state;
    accept             = 1'b0;
    bus.ifu_ready      = 1'b0;
    bus.lsu_ready      = 1'b0;
    bus.mem_ren        = 1'b0;
    bus.mem_wen        = 1'b0;
    bus.ifu_resp_valid = 1'b0;
    bus.lsu_resp_valid = 1'b0;
    case (state)
      IDLE: begin
        bus.ifu_ready = gnt[0];
        bus.lsu_ready = gnt[1];
        accept        = |gnt;
        if (accept) state_nxt = ACCESS;
      end
      ACCESS: begin
        bus.mem_ren = ~req_wen;
        bus.mem_wen = req_wen;
        if (cnt == 4'd0) state_nxt = RESP;
      end
      RESP: begin
        bus.ifu_resp_valid = (req_id == GNT_IFU);
        bus.lsu_resp_valid = (req_id == GNT_LSU);
        state_nxt          = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The request register drives the memory bus directly, so it is stable for the whole access.
  assign bus.mem_raddr = req_addr;
  assign bus.mem_waddr = req_addr;
  assign bus.mem_wdata = req_wdata;
  assign bus.mem_mask  = req_mask;
  assign bus.ifu_rdata = ifu_rdata_q;
  assign bus.lsu_rdata = lsu_rdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      last_grant  <= GNT_LSU;
      req_id      <= GNT_IFU;
      req_wen     <= 1'b0;
      req_addr    <= '0;
      req_wdata   <= '0;
      req_mask    <= 8'h00;
      ifu_rdata_q <= '0;
      lsu_rdata_q <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        last_grant <= gnt_id;
        req_id     <= gnt_id;
        cnt        <= CNT_INIT;
        if (gnt_id == GNT_LSU) begin
          req_wen   <= bus.lsu_wen;
          req_addr  <= bus.lsu_addr;
          req_wdata <= bus.lsu_wdata;
          req_mask  <= bus.lsu_mask;
        end else begin
          req_wen   <= 1'b0;
          req_addr  <= bus.ifu_addr;
          req_wdata <= '0;
          req_mask  <= 8'h00;
        end
      end else if (state == ACCESS) begin
        if (cnt != 4'd0) begin
          cnt <= cnt - 4'd1;
        end else if (req_id == GNT_IFU) begin
          ifu_rdata_q <= bus.mem_rdata;
        end else begin
          lsu_rdata_q <= req_wen ? '0 : bus.mem_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two instances (LATENCY 1 and 3) with a simple memory model,
// a directed vector table, corner-case sequences and randomized traffic.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  typedef struct packed {
    logic        rst;
    logic        iv;
    logic [63:0] ia;
    logic        lv;
    logic        lw;
    logic [63:0] la;
    logic [63:0] lwd;
    logic [7:0]  lm;
  } in_t;

  typedef struct packed {
    logic        ir, lr, irv, lrv, ren, wen;
    logic [63:0] ird, lrd, raddr, waddr, wdata;
    logic [7:0]  mask;
  } out_t;

  typedef struct {
    in_t         i;
    logic [5:0]  f;      // {ifu_ready, lsu_ready, mem_ren, mem_wen, ifu_resp, lsu_resp}
    logic [63:0] eaddr;
    logic [63:0] edata;
    logic [63:0] ewd;
    logic [7:0]  em;
  } vec_t;

  logic        clk = 1'b0;
  in_t         din  [2];
  out_t        dout [2];
  logic [63:0] salt [2];
  int          checks   = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  function automatic logic [63:0] mem_fn(input logic [63:0] a);
    if (a == 64'h8000_0000) return 64'h0010_0093_0000_0013;
    if (a == 64'h0) return 64'h11;
    if (a == 64'h8) return 64'h22;
    return (a * 64'h9E37_79B9_7F4A_7C15) ^ 64'h0123_4567_89AB_CDEF;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : gen_dut
    mem_arbiter_if bus ();
    mem_arbiter #(.LATENCY(g == 0 ? 1 : 3)) dut (
      .clk (clk),
      .rst (din[g].rst),
      .bus (bus)
    );
    assign bus.ifu_valid = din[g].iv;
    assign bus.ifu_addr  = din[g].ia;
    assign bus.lsu_valid = din[g].lv;
    assign bus.lsu_wen   = din[g].lw;
    assign bus.lsu_addr  = din[g].la;
    assign bus.lsu_wdata = din[g].lwd;
    assign bus.lsu_mask  = din[g].lm;
    assign bus.mem_rdata = mem_fn(bus.mem_raddr) ^ salt[g];
    assign dout[g] = {bus.ifu_ready, bus.lsu_ready, bus.ifu_resp_valid, bus.lsu_resp_valid,
                      bus.mem_ren, bus.mem_wen, bus.ifu_rdata, bus.lsu_rdata,
                      bus.mem_raddr, bus.mem_waddr, bus.mem_wdata, bus.mem_mask};
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic in_t vin(input logic rst, iv, input logic [63:0] ia, input logic lv, lw,
                              input logic [63:0] la, lwd, input logic [7:0] lm);
    in_t v;
    v.rst = rst; v.iv = iv; v.ia = ia; v.lv = lv; v.lw = lw;
    v.la = la; v.lwd = lwd; v.lm = lm;
    return v;
  endfunction

  function automatic vec_t vrow(input in_t i, input logic [5:0] f, input logic [63:0] eaddr,
                                edata, ewd, input logic [7:0] em);
    vec_t r;
    r.i = i; r.f = f; r.eaddr = eaddr; r.edata = edata; r.ewd = ewd; r.em = em;
    return r;
  endfunction

  task automatic do_reset(input int d);
    din[d] = vin(1'b1, 1'b0, 64'h0, 1'b0, 1'b0, 64'h0, 64'h0, 8'h0);
    @(negedge clk);
    din[d] = '0;
  endtask

  // Reference: a transaction accepted in cycle N owns cycles N+1..N+lat for strobes,
  // N+lat+1 for the response, and the port is free again from N+lat+2.
  task automatic run_random(input int d, input int lat, input int n);
    in_t v; out_t o;
    bit busy, rid, rwen, last, ip, lp, plw, e_ir, e_lr, in_acc, in_resp, rst_now;
    int t_acc, age;
    logic [63:0] raddr, rwd, m_ird, m_lrd, pia, pla, plwd;
    logic [7:0] rmask, plm;
    do_reset(d);
    busy = 0; last = 1; rid = 0; rwen = 0; t_acc = 0; ip = 0; lp = 0; plw = 0;
    raddr = 0; rwd = 0; rmask = 0; m_ird = 0; m_lrd = 0; pia = 0; pla = 0; plwd = 0; plm = 0;
    for (int k = 0; k < n; k++) begin
      if (!ip && $urandom_range(2) == 0) begin
        ip = 1; pia = {$urandom, $urandom};
      end
      if (!lp && $urandom_range(2) == 0) begin
        lp = 1; plw = 1'($urandom_range(1)); pla = {$urandom, $urandom};
        plwd = {$urandom, $urandom}; plm = 8'($urandom);
      end
      rst_now = ($urandom_range(79) == 0);
      v = vin(rst_now, ip, pia, lp, plw, pla, plwd, plm);
      din[d] = v;
      #1;
      o = dout[d];
      if (busy && (k - t_acc) >= lat + 2) busy = 0;
      age     = k - t_acc;
      in_acc  = busy && age >= 1 && age <= lat;
      in_resp = busy && age == lat + 1;
      e_ir = !busy && ip && (!lp || last);
      e_lr = !busy && lp && (!ip || !last);
      if (in_resp) begin
        if (!rid) m_ird = mem_fn(raddr);
        else m_lrd = rwen ? 64'h0 : mem_fn(raddr);
      end
      chk($sformatf("rnd%0d_c%0d_ifu_ready", d, k), o.ir, e_ir);
      chk($sformatf("rnd%0d_c%0d_lsu_ready", d, k), o.lr, e_lr);
      chk($sformatf("rnd%0d_c%0d_mem_ren", d, k), o.ren, in_acc && !rwen);
      chk($sformatf("rnd%0d_c%0d_mem_wen", d, k), o.wen, in_acc && rwen);
      chk($sformatf("rnd%0d_c%0d_ifu_resp", d, k), o.irv, in_resp && !rid);
      chk($sformatf("rnd%0d_c%0d_lsu_resp", d, k), o.lrv, in_resp && rid);
      chk($sformatf("rnd%0d_c%0d_ifu_rdata", d, k), o.ird, m_ird);
      chk($sformatf("rnd%0d_c%0d_lsu_rdata", d, k), o.lrd, m_lrd);
      if (in_acc && rwen) begin
        chk($sformatf("rnd%0d_c%0d_waddr", d, k), o.waddr, raddr);
        chk($sformatf("rnd%0d_c%0d_wdata", d, k), o.wdata, rwd);
        chk($sformatf("rnd%0d_c%0d_mask", d, k), 64'(o.mask), 64'(rmask));
      end else if (in_acc) begin
        chk($sformatf("rnd%0d_c%0d_raddr", d, k), o.raddr, raddr);
      end
      if (rst_now) begin
        busy = 0; last = 1; m_ird = 0; m_lrd = 0; ip = 0; lp = 0;
      end else if (e_ir || e_lr) begin
        busy = 1; t_acc = k; rid = e_lr; last = e_lr;
        if (e_lr) begin
          rwen = plw; raddr = pla; rwd = plwd; rmask = plm; lp = 0;
        end else begin
          rwen = 0; raddr = pia; ip = 0;
        end
      end
      @(negedge clk);
    end
    din[d] = '0;
  endtask

  initial begin
    vec_t        tbl[$];
    vec_t        r;
    out_t        o;
    in_t         idl, both, rsti;
    logic [63:0] a0, a1;

    a0   = 64'h8000_0000;
    a1   = 64'h8000_1000;
    idl  = '0;
    rsti = vin(1'b1, 1'b0, 64'h0, 1'b0, 1'b0, 64'h0, 64'h0, 8'h0);
    both = vin(1'b0, 1'b1, 64'h100, 1'b1, 1'b0, 64'h200, 64'h0, 8'h0);

    tbl.push_back(vrow(vin(0, 1, a0, 0, 0, 0, 0, 0), 6'b100000, 0, 0, 0, 0));
    tbl.push_back(vrow(idl, 6'b001000, a0, 0, 0, 0));
    tbl.push_back(vrow(idl, 6'b000010, 0, 64'h0010_0093_0000_0013, 0, 0));
    tbl.push_back(vrow(idl, 6'b000000, 0, 0, 0, 0));
    tbl.push_back(vrow(vin(0, 0, 0, 1, 1, a1, 64'hDEAD_BEEF, 8'h0F), 6'b010000, 0, 0, 0, 0));
    tbl.push_back(vrow(idl, 6'b000100, a1, 0, 64'hDEAD_BEEF, 8'h0F));
    tbl.push_back(vrow(idl, 6'b000001, 0, 64'h0, 0, 0));
    tbl.push_back(vrow(idl, 6'b000000, 0, 0, 0, 0));
    tbl.push_back(vrow(rsti, 6'b000000, 0, 0, 0, 0));
    for (int p = 0; p < 2; p++) begin
      tbl.push_back(vrow(both, 6'b100000, 0, 0, 0, 0));
      tbl.push_back(vrow(both, 6'b001000, 64'h100, 0, 0, 0));
      tbl.push_back(vrow(both, 6'b000010, 0, mem_fn(64'h100), 0, 0));
      tbl.push_back(vrow(both, 6'b010000, 0, 0, 0, 0));
      tbl.push_back(vrow(p == 0 ? both : idl, 6'b001000, 64'h200, 0, 0, 0));
      tbl.push_back(vrow(p == 0 ? both : idl, 6'b000001, 0, mem_fn(64'h200), 0, 0));
    end
    tbl.push_back(vrow(idl, 6'b000000, 0, 0, 0, 0));

    salt[0] = '0;
    salt[1] = '0;
    din[0]  = rsti;
    din[1]  = rsti;
    repeat (2) @(negedge clk);
    din[0] = '0;
    din[1] = '0;
    #1;
    for (int d = 0; d < 2; d++) begin
      o = dout[d];
      chk($sformatf("rst%0d_readies", d), {o.ir, o.lr}, 0);
      chk($sformatf("rst%0d_strobes", d), {o.ren, o.wen}, 0);
      chk($sformatf("rst%0d_resp", d), {o.irv, o.lrv}, 0);
      chk($sformatf("rst%0d_rdata", d), o.ird | o.lrd, 0);
      chk($sformatf("rst%0d_addr_data", d), o.raddr | o.waddr | o.wdata, 0);
      chk($sformatf("rst%0d_mask", d), 64'(o.mask), 0);
    end
    @(negedge clk);

    for (int n = 0; n < tbl.size(); n++) begin
      r = tbl[n];
      din[0] = r.i;
      #1;
      o = dout[0];
      chk($sformatf("tbl%0d_ifu_ready", n), o.ir, r.f[5]);
      chk($sformatf("tbl%0d_lsu_ready", n), o.lr, r.f[4]);
      chk($sformatf("tbl%0d_mem_ren", n), o.ren, r.f[3]);
      chk($sformatf("tbl%0d_mem_wen", n), o.wen, r.f[2]);
      chk($sformatf("tbl%0d_ifu_resp", n), o.irv, r.f[1]);
      chk($sformatf("tbl%0d_lsu_resp", n), o.lrv, r.f[0]);
      if (r.f[3]) chk($sformatf("tbl%0d_raddr", n), o.raddr, r.eaddr);
      if (r.f[2]) begin
        chk($sformatf("tbl%0d_waddr", n), o.waddr, r.eaddr);
        chk($sformatf("tbl%0d_wdata", n), o.wdata, r.ewd);
        chk($sformatf("tbl%0d_mask", n), 64'(o.mask), 64'(r.em));
      end
      if (r.f[1]) chk($sformatf("tbl%0d_ifu_rdata", n), o.ird, r.edata);
      if (r.f[0]) chk($sformatf("tbl%0d_lsu_rdata", n), o.lrd, r.edata);
      @(negedge clk);
    end

    // LATENCY=3: the memory data changes every cycle, only the third strobe cycle's value counts.
    din[1] = vin(0, 1, 64'h40, 0, 0, 0, 0, 0);
    #1;
    chk("l3_accept", dout[1].ir, 1);
    chk("l3_ren_c0", dout[1].ren, 0);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      din[1]  = '0;
      salt[1] = 64'(i);
      #1;
      chk($sformatf("l3_ren_c%0d", i), dout[1].ren, 1);
      chk($sformatf("l3_raddr_c%0d", i), dout[1].raddr, 64'h40);
      chk($sformatf("l3_resp_c%0d", i), dout[1].irv, 0);
    end
    @(negedge clk);
    salt[1] = 64'd4;
    #1;
    chk("l3_ren_c4", dout[1].ren, 0);
    chk("l3_resp_c4", dout[1].irv, 1);
    chk("l3_rdata_c4", dout[1].ird, mem_fn(64'h40) ^ 64'd3);
    @(negedge clk);
    salt[1] = '0;
    #1;
    chk("l3_resp_c5", dout[1].irv, 0);
    chk("l3_rdata_hold", dout[1].ird, mem_fn(64'h40) ^ 64'd3);
    @(negedge clk);

    // Reset in the middle of an LSU read discards it.
    do_reset(0);
    din[0] = vin(0, 0, 0, 1, 0, 64'h300, 0, 0);
    #1;
    chk("mrst_accept", dout[0].lr, 1);
    @(negedge clk);
    din[0] = rsti;
    #1;
    chk("mrst_access_ren", dout[0].ren, 1);
    @(negedge clk);
    din[0] = vin(0, 1, 64'h400, 1, 0, 64'h500, 0, 0);
    #1;
    chk("mrst_strobes", {dout[0].ren, dout[0].wen}, 0);
    chk("mrst_no_resp_c2", dout[0].lrv, 0);
    chk("mrst_ifu_first", {dout[0].ir, dout[0].lr}, 2'b10);
    @(negedge clk);
    din[0] = vin(0, 0, 0, 1, 0, 64'h500, 0, 0);
    #1;
    chk("mrst_ifu_ren", dout[0].ren, 1);
    chk("mrst_ifu_raddr", dout[0].raddr, 64'h400);
    chk("mrst_no_resp_c3", dout[0].lrv, 0);
    @(negedge clk);
    #1;
    chk("mrst_ifu_resp", dout[0].irv, 1);
    chk("mrst_no_resp_c4", dout[0].lrv, 0);
    chk("mrst_ifu_rdata", dout[0].ird, mem_fn(64'h400));
    @(negedge clk);
    #1;
    chk("mrst_lsu_next", dout[0].lr, 1);
    @(negedge clk);

    // Back-to-back IFU fetches from 0x0 and 0x8.
    do_reset(0);
    din[0] = vin(0, 1, 64'h0, 0, 0, 0, 0, 0);
    #1;
    chk("b2b_c0_ren", dout[0].ren, 0);
    chk("b2b_c0_ready", dout[0].ir, 1);
    @(negedge clk);
    din[0] = vin(0, 1, 64'h8, 0, 0, 0, 0, 0);
    #1;
    chk("b2b_c1_ren", dout[0].ren, 1);
    chk("b2b_c1_raddr", dout[0].raddr, 64'h0);
    chk("b2b_c1_ready", dout[0].ir, 0);
    @(negedge clk);
    #1;
    chk("b2b_c2_ren", dout[0].ren, 0);
    chk("b2b_c2_resp", dout[0].irv, 1);
    chk("b2b_c2_rdata", dout[0].ird, 64'h11);
    @(negedge clk);
    #1;
    chk("b2b_c3_ren", dout[0].ren, 0);
    chk("b2b_c3_ready", dout[0].ir, 1);
    @(negedge clk);
    din[0] = '0;
    #1;
    chk("b2b_c4_ren", dout[0].ren, 1);
    chk("b2b_c4_raddr", dout[0].raddr, 64'h8);
    @(negedge clk);
    #1;
    chk("b2b_c5_resp", dout[0].irv, 1);
    chk("b2b_c5_rdata", dout[0].ird, 64'h22);
    @(negedge clk);

    run_random(0, 1, 800);
    run_random(1, 3, 800);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
